// File: rtl/chal_resp_sequencer.sv
// Walks the challenge RAM, arms the PUF, samples its bit and packs words for the response RAM.
// Latency: READ_LATENCY + delay+1 + 1 cycles per challenge (+2 sample cycles with SEQ_MAJORITY_EN), +1 per written word.
// No backpressure: the response RAM accepts every write pulse; start is ignored while busy.
module chal_resp_sequencer #(
    parameter int N                        = 256,
    parameter int N_CHALLENGES             = 8,
    parameter int N_RESPONSE_BITS_PER_WORD = 2,
    parameter int N_RESPONSE_WORDS         = 4,
    parameter int N_delays                 = 3,
    parameter int READ_LATENCY             = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [N_delays-1:0]                 delay,
    input  logic                                puf_out,
    output logic [$clog2(N_CHALLENGES)-1:0]     chal_addr,
    output logic                                puf_arm,
    output logic [$clog2(N_RESPONSE_WORDS)-1:0] resp_addr,
    output logic [N_RESPONSE_BITS_PER_WORD-1:0] response,
    output logic                                write,
    output logic                                busy,
    output logic                                done
);

    localparam int IW  = $clog2(N_CHALLENGES);
    localparam int BPW = N_RESPONSE_BITS_PER_WORD;
    localparam int BW  = $clog2(BPW);
    localparam int RW  = $clog2(N_RESPONSE_WORDS);
    localparam int CW  = (N_delays > 8) ? N_delays : 8;
`ifdef SEQ_MAJORITY_EN
    localparam int S_CYC = 3;
`else
    localparam int S_CYC = 1;
`endif
    localparam logic [IW-1:0] IDX_LAST = IW'(N_CHALLENGES - 1);
    localparam logic [IW-1:0] BIT_MASK = IW'(BPW - 1);

    if (N_RESPONSE_WORDS != N_CHALLENGES / BPW) begin : g_bad_word_count
        $error("N_RESPONSE_WORDS must equal N_CHALLENGES / N_RESPONSE_BITS_PER_WORD");
    end
    if (N < 1 || N_CHALLENGES < 2 || READ_LATENCY < 1 || READ_LATENCY > 256) begin : g_bad_params
        $error("chal_resp_sequencer: illegal N, N_CHALLENGES or READ_LATENCY");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ARM,
        S_SAMPLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_nxt;
    logic [IW-1:0]         idx_q, idx_nxt;
    logic [BPW-1:0]        word_q, word_nxt;
    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic [N_delays-1:0]   delay_q, delay_nxt;
    logic [IW-1:0]         bit_pos;
    logic                  sample_bit;

`ifdef SEQ_MAJORITY_EN
    logic [1:0] samp_q;

    // First two samples are held; the third arrives live and the 2-of-3 vote is taken on it.
    always_ff @(posedge clock) begin
        if (reset) begin
            samp_q <= '0;
        end else if (state_q == S_SAMPLE) begin
            samp_q[cnt_q[0]] <= puf_out;
        end
    end

    assign sample_bit = (samp_q[0] & samp_q[1]) | (samp_q[0] & puf_out) | (samp_q[1] & puf_out);
`else
    assign sample_bit = puf_out;
`endif

    assign bit_pos = idx_q & BIT_MASK;

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        word_nxt  = word_q;
        cnt_nxt   = cnt_q;
        delay_nxt = delay_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    idx_nxt   = '0;
                    word_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            S_FETCH: begin
                if (cnt_q == CW'(READ_LATENCY - 1)) begin
                    state_nxt = S_ARM;
                    cnt_nxt   = '0;
                    delay_nxt = delay;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            S_ARM: begin
                if (cnt_q == CW'(delay_q)) begin
                    state_nxt = S_SAMPLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            S_SAMPLE: begin
                if (cnt_q == CW'(S_CYC - 1)) begin
                    cnt_nxt = '0;
                    for (int b = 0; b < BPW; b++) begin
                        if (bit_pos == IW'(b)) word_nxt[b] = sample_bit;
                    end
                    if (bit_pos == BIT_MASK) begin
                        state_nxt = S_WRITE;
                    end else if (idx_q == IDX_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FETCH;
                        idx_nxt   = idx_q + IW'(1);
                    end
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            S_WRITE: begin
                if (idx_q == IDX_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_FETCH;
                    idx_nxt   = idx_q + IW'(1);
                    word_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            delay_q   <= '0;
            chal_addr <= '0;
            puf_arm   <= 1'b0;
            resp_addr <= '0;
            response  <= '0;
            write     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            idx_q     <= idx_nxt;
            word_q    <= word_nxt;
            cnt_q     <= cnt_nxt;
            delay_q   <= delay_nxt;
            chal_addr <= idx_nxt;
            puf_arm   <= (state_nxt == S_ARM);
            write     <= (state_nxt == S_WRITE);
            busy      <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            done      <= (state_nxt == S_DONE);
            if (state_nxt == S_WRITE) begin
                response  <= word_nxt;
                resp_addr <= RW'(idx_nxt >> BW);
            end
        end
    end

endmodule
